ib_div_16x8_seq: RTL and testbench

IB_DIV_16X8_SEQ -- requirements
Module: ib_div_16x8_seq

---
 rtl/ib_div_16x8_seq_pkg.sv | 16 +
 rtl/ib_div_16x8_seq_if.sv | 26 ++
 rtl/ib_div_16x8_seq_step.sv | 23 ++
 rtl/ib_div_16x8_seq.sv | 107 ++++++++++
 tb/tb_ib_div_16x8_seq.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/ib_div_16x8_seq_pkg.sv
// Shared widths and state encoding for the 16/8 sequential restoring divider.
package ib_div_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int STEPS      = 16;
    localparam int CNT_W      = 5;

    // Control states: waiting for a request, iterating, presenting a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/ib_div_16x8_seq_if.sv
// Request/result handshake bundle for the divider.
// The master modport is the requester/consumer; the slave modport is the divider.
interface ib_div_16x8_seq_if;
    import ib_div_pkg::*;

    logic                  i_valid;
    logic                  o_ready;
    logic [DIVIDEND_W-1:0] i_a;
    logic [DIVISOR_W-1:0]  i_b;
    logic                  o_valid;
    logic                  i_ready;
    logic [DIVIDEND_W-1:0] o_q;
    logic [DIVISOR_W-1:0]  o_r;
    logic                  o_dbz;

    modport master (
        output i_valid, i_a, i_b, i_ready,
        input  o_ready, o_valid, o_q, o_r, o_dbz
    );

    modport slave (
        input  i_valid, i_a, i_b, i_ready,
        output o_ready, o_valid, o_q, o_r, o_dbz
    );

endinterface

// File: rtl/ib_div_16x8_seq_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and report the quotient bit.
// The shifted remainder is 9 bits so divisors of 128 and above cannot overflow.
module ib_div_step
    import ib_div_pkg::*;
(
    input  logic [DIVISOR_W-1:0] rem,
    input  logic                 dvd_bit,
    input  logic [DIVISOR_W-1:0] b,
    output logic [DIVISOR_W-1:0] rem_next,
    output logic                 q_bit
);

    logic [DIVISOR_W:0] rem9;
    logic [DIVISOR_W:0] diff;

    assign rem9     = {rem, dvd_bit};
    assign diff     = rem9 - {1'b0, b};
    assign q_bit    = (rem9 >= {1'b0, b});
    // After a successful subtract the result is below b, so 8 bits suffice.
    assign rem_next = q_bit ? diff[DIVISOR_W-1:0] : rem9[DIVISOR_W-1:0];

endmodule

// File: rtl/ib_div_16x8_seq.sv
// 16-bit by 8-bit unsigned sequential divider, one restoring step per clock.
// A request is taken only in IDLE; a zero divisor short-circuits straight to
// DONE. The result registers hold their value until the next result lands.
module ib_div_16x8_seq
    import ib_div_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_nrst,
    ib_div_16x8_seq_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    state_e                state;
    logic [CNT_W-1:0]      cnt;
    logic [DIVIDEND_W-1:0] dvd;      // dividend bits shift out, quotient bits shift in
    logic [DIVISOR_W-1:0]  rem;
    logic [DIVISOR_W-1:0]  b_q;
    logic [DIVIDEND_W-1:0] q_r;
    logic [DIVISOR_W-1:0]  r_r;
    logic                  dbz_r;

    logic                  accept;
    logic                  b_zero;
    logic                  last_step;
    logic [DIVISOR_W-1:0]  rem_next;
    logic                  q_bit;

    assign accept    = bus.i_valid && (state == IDLE);
    assign b_zero    = (bus.i_b == '0);
    assign last_step = (state == CALC) && (cnt == LAST_STEP);

    ib_div_step u_step (
        .rem      (rem),
        .dvd_bit  (dvd[DIVIDEND_W-1]),
        .b        (b_q),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // Control: state transitions and the step counter that alone ends CALC.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            // NOTE: registers use non-blocking assignments so every update in this edge sees pre-edge values.
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt   <= '0;
                        state <= b_zero ? DONE : CALC;
                    end
                end
                CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_STEP) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.i_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: operand capture, iteration, and the held result registers.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            // NOTE: the working registers are reset as well; they are few and it keeps every output defined from reset.
            dvd   <= '0;
            rem   <= '0;
            b_q   <= '0;
            q_r   <= '0;
            r_r   <= '0;
            dbz_r <= 1'b0;
        end else if (accept) begin
            dvd <= bus.i_a;
            b_q <= bus.i_b;
            rem <= '0;
            if (b_zero) begin
                q_r   <= '1;
                r_r   <= bus.i_a[DIVISOR_W-1:0];
                dbz_r <= 1'b1;
            end
        end else if (state == CALC) begin
            dvd <= {dvd[DIVIDEND_W-2:0], q_bit};
            rem <= rem_next;
            if (last_step) begin
                q_r   <= {dvd[DIVIDEND_W-2:0], q_bit};
                r_r   <= rem_next;
                dbz_r <= 1'b0;
            end
        end
    end

    assign bus.o_ready = (state == IDLE);
    assign bus.o_valid = (state == DONE);
    assign bus.o_q     = q_r;
    assign bus.o_r     = r_r;
    assign bus.o_dbz   = dbz_r;

endmodule

// File: tb/tb_ib_div_16x8_seq.sv
// Self-checking bench for ib_div_16x8_seq: directed cases followed by random
// operand pairs compared against plain a/b and a%b arithmetic.
module tb_ib_div_16x8_seq;

    logic clk;
    logic nrst;
    int   n_cmp;
    int   n_bad;

    ib_div_16x8_seq_if ifc ();

    ib_div_16x8_seq dut (
        .i_clk  (clk),
        .i_nrst (nrst),
        .bus    (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request at a negedge in IDLE; return at the negedge after the
    // accept edge with fresh garbage on the operand inputs.
    task automatic start(input logic [15:0] a, input logic [7:0] b);
        ifc.i_valid = 1'b1;
        ifc.i_a     = a;
        ifc.i_b     = b;
        check("ready_before_accept", 32'(ifc.o_ready), 32'd1);
        @(negedge clk);
        ifc.i_valid = 1'b0;
        ifc.i_a     = 16'($urandom);
        ifc.i_b     = 8'($urandom);
    endtask

    // Wait (bounded) for o_valid, then check latency and result against the model.
    task automatic wait_result(input logic [15:0] a, input logic [7:0] b);
        int          lat;
        logic [15:0] eq;
        logic [7:0]  er;
        lat = 0;
        eq  = (b == 0) ? 16'hFFFF : a / 16'(b);
        er  = (b == 0) ? a[7:0] : 8'(a % 16'(b));
        while (ifc.o_valid !== 1'b1 && lat < 40) begin
            if (lat == 8) check("ready_low_busy", 32'(ifc.o_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), (b == 0) ? 32'd0 : 32'd16);
        check("q", 32'(ifc.o_q), 32'(eq));
        check("r", 32'(ifc.o_r), 32'(er));
        check("dbz", 32'(ifc.o_dbz), (b == 0) ? 32'd1 : 32'd0);
        check("ready_in_done", 32'(ifc.o_ready), 32'd0);
    endtask

    // Hold backpressure for hold cycles, then handshake; results must stay put.
    task automatic finish(input int hold);
        logic [15:0] q0;
        logic [7:0]  r0;
        logic        d0;
        q0 = ifc.o_q;
        r0 = ifc.o_r;
        d0 = ifc.o_dbz;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_valid", 32'(ifc.o_valid), 32'd1);
            check("hold_q", 32'(ifc.o_q), 32'(q0));
            check("hold_r", 32'(ifc.o_r), 32'(r0));
        end
        ifc.i_ready = 1'b1;
        @(negedge clk);
        ifc.i_ready = 1'b0;
        check("valid_after_hs", 32'(ifc.o_valid), 32'd0);
        check("ready_after_hs", 32'(ifc.o_ready), 32'd1);
        check("idle_keep_q", 32'(ifc.o_q), 32'(q0));
        check("idle_keep_r", 32'(ifc.o_r), 32'(r0));
        check("idle_keep_dbz", 32'(ifc.o_dbz), 32'(d0));
    endtask

    task automatic run_op(input logic [15:0] a, input logic [7:0] b, input int hold);
        start(a, b);
        wait_result(a, b);
        finish(hold);
    endtask

    initial begin
        logic [15:0] ra;
        logic [7:0]  rb;
        n_cmp       = 0;
        n_bad       = 0;
        ifc.i_valid = 1'b0;
        ifc.i_ready = 1'b0;
        ifc.i_a     = '0;
        ifc.i_b     = '0;

        // Asynchronous reset, checked before any clock edge.
        nrst = 1'b1;
        #1 nrst = 1'b0;
        #1;
        check("rst_ready", 32'(ifc.o_ready), 32'd1);
        check("rst_valid", 32'(ifc.o_valid), 32'd0);
        check("rst_q", 32'(ifc.o_q), 32'd0);
        check("rst_r", 32'(ifc.o_r), 32'd0);
        check("rst_dbz", 32'(ifc.o_dbz), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        // Basic and extreme operands, then divide-by-zero.
        run_op(16'd1000, 8'd7, 0);
        run_op(16'hFFFF, 8'd1, 1);
        run_op(16'hFFFF, 8'hFF, 0);
        run_op(16'd0, 8'd200, 0);
        run_op(16'd5, 8'd0, 0);

        // Backpressure with a competing request held high in DONE.
        start(16'd300, 8'd255);
        wait_result(16'd300, 8'd255);
        ifc.i_valid = 1'b1;
        ifc.i_a     = 16'd50;
        ifc.i_b     = 8'd5;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", 32'(ifc.o_valid), 32'd1);
            check("bp_ready", 32'(ifc.o_ready), 32'd0);
            check("bp_q", 32'(ifc.o_q), 32'd1);
            check("bp_r", 32'(ifc.o_r), 32'd45);
        end
        ifc.i_ready = 1'b1;
        @(negedge clk);
        ifc.i_ready = 1'b0;
        check("bp_second_not_taken", 32'(ifc.o_ready), 32'd1);
        check("bp_q_kept", 32'(ifc.o_q), 32'd1);
        @(negedge clk);
        ifc.i_valid = 1'b0;
        wait_result(16'd50, 8'd5);
        finish(0);

        // Reset in the middle of CALC aborts the operation.
        start(16'd1000, 8'd7);
        for (int k = 0; k < 8; k++) @(negedge clk);
        #1 nrst = 1'b0;
        #1;
        check("mid_rst_ready", 32'(ifc.o_ready), 32'd1);
        check("mid_rst_valid", 32'(ifc.o_valid), 32'd0);
        check("mid_rst_q", 32'(ifc.o_q), 32'd0);
        check("mid_rst_r", 32'(ifc.o_r), 32'd0);
        check("mid_rst_dbz", 32'(ifc.o_dbz), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 19) check("no_result_after_abort", 32'(ifc.o_valid), 32'd0);
        end
        run_op(16'd100, 8'd10, 0);

        // Random operands with random request gaps and consumer stalls.
        for (int n = 0; n < 2000; n++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) @(negedge clk);
            ra = 16'($urandom);
            rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            run_op(ra, rb, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
